// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 architectural register file, two async read ports, one sync write port, x0 hardwired to zero
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_ad,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [ADDR_WIDTH-1:0] address2,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] register [NUM_REGS];
  logic                  wr_accept;

  // A write lands only when enabled and not aimed at x0; x0 is never stored to,
  // so it stays at its reset value of zero forever.
  always_comb begin
    wr_accept = write_en && (write_ad != '0);
  end

  // Storage: asynchronous clear of the whole array, otherwise one-edge write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        register[i] <= '0;
      end
    end else if (wr_accept) begin
      register[write_ad] <= data_in;
    end
  end

  // Read ports: purely combinational, no write-to-read bypass.
  always_comb begin
    data_out1 = register[address1];
    data_out2 = register[address2];
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [4:0]  write_ad;
  logic [31:0] data_in;
  logic [4:0]  address1;
  logic [4:0]  address2;
  logic [31:0] data_out1;
  logic [31:0] data_out2;

  int total = 0;
  int bad   = 0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .write_ad  (write_ad),
    .data_in   (data_in),
    .address1  (address1),
    .address2  (address2),
    .data_out1 (data_out1),
    .data_out2 (data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    write_en = 1'b0;
    write_ad = '0;
    data_in  = '0;
    address1 = '0;
    address2 = '0;

    // reset held for two clocks
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("reset_reg%0d", i), dut.register[i], 32'h0);
    end
    address1 = 5'd7;
    address2 = 5'd31;
    #1;
    check("reset_out1", data_out1, 32'h0);
    check("reset_out2", data_out2, 32'h0);

    // write disabled
    @(negedge clk);
    reset    = 1'b1;
    write_en = 1'b0;
    write_ad = 5'd9;
    data_in  = 32'hAFAE2E03;
    address2 = 5'd9;
    @(posedge clk);
    #1;
    check("wr_disabled_out2", data_out2, 32'h0);

    // write then read on both ports
    @(negedge clk);
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    check("wr9_out2", data_out2, 32'hAFAE2E03);
    address1 = 5'd9;
    #1;
    check("wr9_out1", data_out1, 32'hAFAE2E03);
    address2 = 5'd15;
    #1;
    check("unwritten15_out2", data_out2, 32'h0);

    // two writes on consecutive edges
    @(negedge clk);
    write_en = 1'b1;
    write_ad = 5'd20;
    data_in  = 32'hFF34A018;
    @(negedge clk);
    write_ad = 5'd30;
    data_in  = 32'h1010AAEF;
    @(negedge clk);
    write_ad = 5'd0;
    data_in  = 32'hFFFFFFFF;
    @(negedge clk);
    write_en = 1'b0;
    address1 = 5'd20;
    address2 = 5'd30;
    #1;
    check("wr20_out1", data_out1, 32'hFF34A018);
    check("wr30_out2", data_out2, 32'h1010AAEF);
    address1 = 5'd0;
    address2 = 5'd9;
    #1;
    check("x0_out1", data_out1, 32'h0);
    check("x0_array", dut.register[0], 32'h0);
    check("reg9_undisturbed", data_out2, 32'hAFAE2E03);

    // write_en low: data_in change must not land
    data_in  = 32'h12345678;
    write_ad = 5'd20;
    @(posedge clk);
    #1;
    address1 = 5'd20;
    #1;
    check("no_wr_en_reg20", data_out1, 32'hFF34A018);

    // asynchronous reset mid-cycle, no clock edge
    @(posedge clk);
    #2;
    address1 = 5'd20;
    address2 = 5'd30;
    #1;
    check("pre_areset_out2", data_out2, 32'h1010AAEF);
    reset = 1'b0;
    #1;
    check("areset_out1", data_out1, 32'h0);
    check("areset_out2", data_out2, 32'h0);

    // write attempted while reset held across an edge is lost
    write_en = 1'b1;
    write_ad = 5'd20;
    data_in  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("reset_blocks_wr_out1", data_out1, 32'h0);
    check("reset_blocks_wr_arr", dut.register[20], 32'h0);
    check("areset_reg9", dut.register[9], 32'h0);

    // release and check no write-to-read bypass
    @(negedge clk);
    reset    = 1'b1;
    write_en = 1'b1;
    write_ad = 5'd3;
    address1 = 5'd3;
    data_in  = 32'hABCDEFFF;
    #1;
    check("bypass_pre_edge", data_out1, 32'h0);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    check("bypass_post_edge", data_out1, 32'hABCDEFFF);
    address2 = 5'd3;
    #1;
    check("same_addr_out2", data_out2, 32'hABCDEFFF);
    address2 = 5'd20;
    #1;
    check("reg20_still_clear", data_out2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
